// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: TX-side byte FIFO plus handshake stage in front of the UART
// transmit controller. Bytes are shown at the FIFO head with tx_valid and are
// popped only when the transmitter acknowledges by raising its busy flag.
// Optional build macro: UART_TX_FEEDER_GAP_EN inserts GAP_CYCLES idle cycles
// after each frame before the next byte is presented.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  tx_busy,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data
);

`ifdef UART_TX_FEEDER_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, SENDING = 2'd2, GAP = 2'd3} state_t;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, SENDING = 2'd2} state_t;
`endif

  // Reject configurations the pointer arithmetic cannot support.
  if (DEPTH < 2 || DEPTH != (1 << ADDR_WIDTH) || GAP_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_feeder: DEPTH must be 2**ADDR_WIDTH (>=2) and GAP_CYCLES >= 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  busy_q;
  state_t                state;
  logic                  rise, pop, wr_ok;

  assign full     = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty    = (count == '0);
  assign rise     = tx_busy & ~busy_q;
  assign pop      = (state == PRESENT) & rise;
  // full is the pre-edge value, so a write while full is rejected even if a
  // pop lands on the same edge.
  assign wr_ok    = wr_en & ~full;
  assign tx_valid = (state == PRESENT);
  assign tx_data  = mem[rd_ptr];

  // Storage array: no reset, contents only meaningful below count.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, sticky overflow and busy history.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= tx_busy;
      if (wr_en && full) overflow <= 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Handshake FSM: present head, wait for busy rise, wait for busy fall.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
`ifdef UART_TX_FEEDER_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE:    if (!empty) state <= PRESENT;
        // A busy level already high on entry is not a rise; keep waiting.
        PRESENT: if (rise) state <= SENDING;
`ifdef UART_TX_FEEDER_GAP_EN
        SENDING: if (!tx_busy) begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
`else
        SENDING: if (!tx_busy) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: accepted writes push to exp_q, each
// transmitter handshake pops and compares the presented byte.
module tb_uart_tx_feeder;
  localparam int DW = 8, DEPTH = 8, AW = 3, GAPC = 4;

  logic          CLK = 0, RST = 0, wr_en = 0, tx_busy = 0;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty, overflow, tx_valid;
  logic [AW:0]   count;
  logic [DW-1:0] tx_data;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] exp_q[$];

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .GAP_CYCLES(GAPC)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx_busy(tx_busy), .tx_valid(tx_valid), .tx_data(tx_data)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  // Drive one write for one cycle; caller clears wr_en after a burst.
  task automatic wr_byte(input logic [DW-1:0] d, input bit acc);
    wr_en = 1'b1; wr_data = d;
    if (acc) exp_q.push_back(d);
    @(negedge CLK);
  endtask

  // Model transmitter: wait for valid, hold it one more cycle, raise busy for
  // frame_len cycles. Optionally writes on the pop edge and checks count after.
  task automatic serve(input int frame_len, input bit wr_on_pop, input logic [DW-1:0] wdat,
                       input int cnt_after);
    int t; logic [DW-1:0] e;
    t = 0;
    while (tx_valid !== 1'b1 && t < 100) begin @(negedge CLK); t++; end
    n_tests++;
    if (tx_valid !== 1'b1) begin
      n_fail++; $display("FAIL serve_wait: tx_valid=%b want 1", tx_valid); return;
    end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL serve_extra: tx_data=%h with empty scoreboard", tx_data); return;
    end
    e = exp_q.pop_front();
    n_tests++;
    if (tx_data !== e) begin n_fail++; $display("FAIL serve_data: got %h want %h", tx_data, e); end
    @(negedge CLK);
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== e) begin
      n_fail++; $display("FAIL serve_hold: valid=%b data=%h want 1/%h", tx_valid, tx_data, e);
    end
    tx_busy = 1'b1;
    if (wr_on_pop) begin wr_en = 1'b1; wr_data = wdat; exp_q.push_back(wdat); end
    @(negedge CLK);
    wr_en = 1'b0;
    n_tests++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL serve_drop: tx_valid=%b want 0", tx_valid); end
    if (cnt_after >= 0) begin
      n_tests++;
      if (count !== AW'(0) + cnt_after[AW:0]) begin
        n_fail++; $display("FAIL serve_count: count=%0d want %0d", count, cnt_after);
      end
    end
    for (int i = 1; i < frame_len; i++) begin
      @(negedge CLK);
      n_tests++;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL valid_while_busy: tx_valid=%b want 0", tx_valid); end
    end
    tx_busy = 1'b0;
  endtask

  task automatic test_reset;
    RST = 0; wr_en = 1; wr_data = 8'hFF;
    repeat (2) @(negedge CLK);
    wr_en = 0;
    n_tests++;
    if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || tx_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%0d empty=%b full=%b valid=%b ovf=%b want 0/1/0/0/0",
               count, empty, full, tx_valid, overflow);
    end
    RST = 1;
    @(negedge CLK);
    n_tests++;
    if (count !== 0 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_nowrite: count=%0d valid=%b want 0/0", count, tx_valid);
    end
  endtask

  task automatic test_single;
    wr_byte(8'hA5, 1); wr_en = 0;
    n_tests++;
    if (count !== 1 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_lat1: count=%0d valid=%b want 1/0", count, tx_valid);
    end
    @(negedge CLK);
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++; $display("FAIL single_lat2: valid=%b data=%h want 1/a5", tx_valid, tx_data);
    end
    serve(4, 0, '0, 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_burst;
    wr_byte(8'h11, 1); wr_byte(8'h22, 1); wr_byte(8'h33, 1); wr_en = 0;
    for (int i = 0; i < 3; i++) serve(12, 0, '0, 2 - i);
    repeat (3) @(negedge CLK);
    n_tests++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL burst_end: left=%0d valid=%b empty=%b want 0/0/1", exp_q.size(), tx_valid, empty);
    end
  endtask

  task automatic test_full_overflow;
    for (int i = 0; i < 8; i++) wr_byte(8'hB0 + 8'(i), 1);
    n_tests++;
    if (full !== 1'b1 || count !== 8 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_at8: full=%b count=%0d ovf=%b want 1/8/0", full, count, overflow);
    end
    wr_byte(8'h99, 0); wr_en = 0;
    n_tests++;
    if (overflow !== 1'b1 || count !== 8 || full !== 1'b1) begin
      n_fail++; $display("FAIL overflow: ovf=%b count=%0d full=%b want 1/8/1", overflow, count, full);
    end
    for (int i = 0; i < 8; i++) serve(3, 0, '0, 7 - i);
    repeat (3) @(negedge CLK);
    n_tests++;
    if (empty !== 1'b1 || tx_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_drain: empty=%b valid=%b ovf=%b want 1/0/1", empty, tx_valid, overflow);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) wr_byte(8'h40 + 8'(i), 1);
    wr_en = 0;
    for (int i = 0; i < 20; i++) serve(3, 1, 8'h80 + 8'(i), 4);
    for (int i = 0; i < 4; i++) serve(3, 0, '0, 3 - i);
    repeat (3) @(negedge CLK);
    n_tests++;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_end: empty=%b left=%0d want 1/0", empty, exp_q.size());
    end
  endtask

  task automatic test_gap;
    int t, f, v, exp_gap;
`ifdef UART_TX_FEEDER_GAP_EN
    exp_gap = GAPC + 1;
`else
    exp_gap = 1;
`endif
    wr_byte(8'h5A, 1); wr_byte(8'hC3, 1); wr_en = 0;
    t = 0;
    while (tx_valid !== 1'b1 && t < 50) begin @(negedge CLK); t++; end
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
      n_fail++; $display("FAIL gap_first: valid=%b data=%h want 1/5a", tx_valid, tx_data);
    end
    void'(exp_q.pop_front());
    @(negedge CLK);
    tx_busy = 1;
    repeat (12) @(negedge CLK);
    tx_busy = 0;
    f = cyc + 1;
    t = 0;
    while (tx_valid !== 1'b1 && t < 50) begin @(negedge CLK); t++; end
    v = cyc;
    n_tests++;
    if (tx_valid !== 1'b1 || v - f != exp_gap) begin
      n_fail++; $display("FAIL gap_cycles: got %0d want %0d (valid=%b)", v - f, exp_gap, tx_valid);
    end
    serve(3, 0, '0, 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    wr_byte(8'h01, 1); wr_byte(8'h02, 1); wr_en = 0;
    @(negedge CLK);
    n_tests++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: valid=%b want 1", tx_valid); end
    RST = 0;
    @(negedge CLK);
    n_tests++;
    if (tx_valid !== 1'b0 || count !== 0 || empty !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: valid=%b count=%0d empty=%b ovf=%b want 0/0/1/0",
                         tx_valid, count, empty, overflow);
    end
    RST = 1;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    n_tests++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after: valid=%b want 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_wrap();
    test_gap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Single-clock TX-side buffer and handshake stage directly upstream of the UART transmit controller.
- Queues bytes written by the system controller in a small synchronous FIFO.
- Presents the head byte with a valid strobe, and pops it only once the UART transmitter signals acceptance by raising its busy flag.
- Guarantees one frame per byte: no drops while the transmitter is busy and no duplicate starts.

Parameters:
- DATA_WIDTH, 8, width of each queued byte/word.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- ADDR_WIDTH, 3, log2(DEPTH); pointer width.
- GAP_CYCLES, 4, idle cycles inserted between frames; used only when the optional feature is compiled in.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-low reset.
- wr_en  input  1  write strobe from the system controller.
- wr_data  input  DATA_WIDTH  byte to queue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was attempted while full.
- tx_busy  input  1  registered busy flag from the UART transmit controller.
- tx_valid  output  1  Data_Valid to the UART transmit controller.
- tx_data  output  DATA_WIDTH  parallel data to the UART transmit path.

Behaviour:
- Reset: CLK with RST=0 clears pointers, count and busy_q, and sets state=IDLE. Result: tx_valid=0, full=0, empty=1, count=0, overflow=0.
- Reset mid-operation discards all queued bytes and drops tx_valid on the next edge.
- tx_data is never reset; it shows the FIFO head (show-ahead) and is undefined while empty.
- Write: wr_en=1 and !full stores wr_data at wr_ptr on the edge; wr_ptr wraps DEPTH-1 -> 0.
- Write while full: data dropped, overflow set to 1 and held until reset.
- Pop: occurs only on the busy-rise event in state PRESENT. rd_ptr increments with wrap; count decrements.
- Simultaneous write and pop: count unchanged. A write when full and a pop in the same cycle is still rejected, because full is evaluated before the edge.
- full, empty and count are all derived from the count register.
- Busy edge detect: busy_q <= tx_busy each cycle; rise = tx_busy & ~busy_q.
- State machine, with the state register updated on the clock edge:
  - IDLE: if !empty -> PRESENT.
  - PRESENT: tx_valid=1, tx_data held stable. On rise: pop and go to SENDING; tx_valid is 0 from the next cycle.
  - SENDING: tx_valid=0. When tx_busy==0 -> IDLE, or -> GAP if the feature is enabled.
  - GAP (feature only): counts GAP_CYCLES cycles, then -> IDLE.
  - Unused encodings -> IDLE.
- tx_valid is decoded from state only (state==PRESENT); it is never combinational on inputs.
- Latency: a write on edge E0 into an empty FIFO gives PRESENT after E1, so tx_valid is high in the cycle after E1.
- Handshake: tx_valid stays high, with tx_data unchanged, until the busy rise. This covers the transmitter's one-cycle start state and its one-cycle registered busy lag.
- tx_valid is never raised while tx_busy=1. This prevents a restart during the transmitter's busy lag after its stop state.
- If tx_busy is already high on entry to PRESENT (misuse), no rise is seen. The block waits in PRESENT until a new rise occurs.
- Back-to-back frames: minimum of one IDLE cycle between a busy fall and the next tx_valid.

Optional Feature:
- Macro: UART_TX_FEEDER_GAP_EN.
- Defined: the SENDING-to-GAP path exists. A counter of width ceil(log2(GAP_CYCLES+1)) loads 0 on entry to GAP and leaves for IDLE when it reaches GAP_CYCLES-1. This adds GAP_CYCLES idle cycles before the next tx_valid.
- Not defined: no GAP state and no counter; SENDING goes directly to IDLE.

Test Plan:
- Reset: hold RST=0 for 2 edges with wr_en=1 -> count=0, empty=1, tx_valid=0, overflow=0; no write accepted.
- Single byte: write 0xA5 into an empty FIFO -> tx_valid high 2 cycles later with tx_data=0xA5. A model busy rises 2 cycles after valid -> tx_valid low next cycle, count=0.
- Burst: write 0x11, 0x22, 0x33 back-to-back, with a model transmitter taking 12 cycles per frame -> exactly three valid windows in order 0x11, 0x22, 0x33. tx_valid is never high while tx_busy=1.
- Full and overflow: write 9 bytes with DEPTH=8 and busy held low -> full=1 after the 8th write, overflow=1 after the 9th. The 9th byte is absent from the output.
- Wrap and simultaneous access: cycle 20 bytes with a write landing on the same edge as each pop -> count stable, pointers wrap, output order matches input.
- Gap (macro on, GAP_CYCLES=4): two queued bytes -> exactly 5 cycles from the first busy fall to the second tx_valid (4 gap + 1 IDLE). With the macro off -> 1 cycle.
